metric_sorter: RTL and testbench

- Downstream consumer of the dotProduct stage in the V2V detector chain.
- Accepts a stream of complex candidate results and computes each squared Euclidean metric (re^2 + im^2).
- Keeps the K smallest metrics with their candidate indices in a sorted insertion register array.
- After the constellation's full candidate count has arrived, drains the survivors in rank order over a valid/ready handshake to the next (tree-search) stage.

---
 rtl/sorter_pkg.sv | 30 +++
 rtl/sq_magnitude.sv | 44 ++++
 rtl/metric_sorter.sv | 182 ++++++++++++++++++
 tb/tb_metric_sorter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared definitions for the metric sorter: modulation codes, candidate
// counts per constellation and the sorter FSM state encoding.
package sorter_pkg;

  localparam logic [1:0] MOD_QPSK   = 2'b00;
  localparam logic [1:0] MOD_QAM16  = 2'b01;
  localparam logic [1:0] MOD_QAM64  = 2'b10;
  localparam logic [1:0] MOD_QAM256 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_FLUSH   = 3'd2,
    S_OUTPUT  = 3'd3,
    S_DONE    = 3'd4
  } sorterState;

  // 9 bits so QAM256 (256 candidates) is representable.
  function automatic logic [8:0] numCandidates(input logic [1:0] mod);
    logic [8:0] n;
    case (mod)
      MOD_QPSK:  n = 9'd4;
      MOD_QAM16: n = 9'd16;
      MOD_QAM64: n = 9'd64;
      default:   n = 9'd256;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sq_magnitude.sv
// Registered complex squared-magnitude unit: metric = re^2 + im^2 with the
// candidate index and valid flag carried alongside, one cycle of latency.
module sq_magnitude
  import sorter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] re,
  input  logic signed [WIDTH-1:0] im,
  input  logic [IDX_WIDTH-1:0]    idx,
  input  logic                    valid,
  output logic [2*WIDTH-1:0]      metric,
  output logic [IDX_WIDTH-1:0]    metricIdx,
  output logic                    metricValid
);

  logic signed [2*WIDTH-1:0] reSq;
  logic signed [2*WIDTH-1:0] imSq;
  logic [2*WIDTH-1:0]        sumSq;

  // Each square is non-negative and at most 2^(2W-2), so the unsigned sum
  // of two of them always fits in 2W bits.
  always_comb begin
    reSq  = re * re;
    imSq  = im * im;
    sumSq = $unsigned(reSq) + $unsigned(imSq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      metric      <= '0;
      metricIdx   <= '0;
      metricValid <= 1'b0;
    end else begin
      metric      <= sumSq;
      metricIdx   <= idx;
      metricValid <= valid;
    end
  end

endmodule

// File: rtl/metric_sorter.sv
// Keeps the K smallest squared metrics of a candidate stream in a sorted
// insertion array and drains them in rank order over valid/ready.
module metric_sorter
  import sorter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 8,
  parameter int K         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              M,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic signed [WIDTH-1:0] inReal,
  input  logic signed [WIDTH-1:0] inImag,
  input  logic [IDX_WIDTH-1:0]    inIdx,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [2*WIDTH-1:0]      outMetric,
  output logic [IDX_WIDTH-1:0]    outIdx,
  output logic [3:0]              outRank,
  output logic                    busy,
  output logic                    done
);

  localparam logic [8:0] K_COUNT = 9'(K);

  sorterState stateReg, stateNext;
  logic [8:0] nReg;
  logic [8:0] countReg;
  logic [3:0] rankReg;
  logic [8:0] lastRank;
  logic       accept;
  logic       clearList;

  logic [2*WIDTH-1:0]   sqMetric;
  logic [IDX_WIDTH-1:0] sqIdx;
  logic                 sqValid;

  logic [2*WIDTH-1:0]   listMetricReg  [K];
  logic [2*WIDTH-1:0]   listMetricNext [K];
  logic [IDX_WIDTH-1:0] listIdxReg     [K];
  logic [IDX_WIDTH-1:0] listIdxNext    [K];
  logic [K-1:0]         listValidReg;
  logic [K-1:0]         listValidNext;
  logic [K-1:0]         beats;

  assign accept    = inValid && inReady;
  assign clearList = (stateReg == S_IDLE) && start;
  assign lastRank  = ((K_COUNT < nReg) ? K_COUNT : nReg) - 9'd1;

  sq_magnitude #(
    .WIDTH    (WIDTH),
    .IDX_WIDTH(IDX_WIDTH)
  ) uSqMag (
    .clk        (clk),
    .rst        (rst),
    .re         (inReal),
    .im         (inImag),
    .idx        (inIdx),
    .valid      (accept),
    .metric     (sqMetric),
    .metricIdx  (sqIdx),
    .metricValid(sqValid)
  );

  // beats[] is monotonic over rank because the list is kept sorted with
  // valid entries first; the new entry lands at the first set bit and every
  // rank after it takes its predecessor. Equal metrics do not beat, so ties
  // keep arrival order.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : gRank
      assign beats[gi] = !listValidReg[gi] || (listMetricReg[gi] > sqMetric);
      if (gi == 0) begin : gHead
        assign listMetricNext[gi] = clearList ? '1 :
                                    (sqValid && beats[gi]) ? sqMetric : listMetricReg[gi];
        assign listIdxNext[gi]    = clearList ? '0 :
                                    (sqValid && beats[gi]) ? sqIdx : listIdxReg[gi];
        assign listValidNext[gi]  = clearList ? 1'b0 :
                                    (sqValid && beats[gi]) ? 1'b1 : listValidReg[gi];
      end else begin : gTail
        assign listMetricNext[gi] = clearList ? '1 :
                                    !(sqValid && beats[gi]) ? listMetricReg[gi] :
                                    beats[gi-1] ? listMetricReg[gi-1] : sqMetric;
        assign listIdxNext[gi]    = clearList ? '0 :
                                    !(sqValid && beats[gi]) ? listIdxReg[gi] :
                                    beats[gi-1] ? listIdxReg[gi-1] : sqIdx;
        assign listValidNext[gi]  = clearList ? 1'b0 :
                                    !(sqValid && beats[gi]) ? listValidReg[gi] :
                                    beats[gi-1] ? listValidReg[gi-1] : 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        listMetricReg[i] <= '1;
        listIdxReg[i]    <= '0;
      end
      listValidReg <= '0;
    end else begin
      for (int i = 0; i < K; i++) begin
        listMetricReg[i] <= listMetricNext[i];
        listIdxReg[i]    <= listIdxNext[i];
      end
      listValidReg <= listValidNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= S_IDLE;
      nReg     <= '0;
      countReg <= '0;
      rankReg  <= '0;
    end else begin
      stateReg <= stateNext;
      if (clearList) begin
        nReg     <= numCandidates(M);
        countReg <= '0;
        rankReg  <= '0;
      end else begin
        if (accept) begin
          countReg <= countReg + 9'd1;
        end
        if (outValid && outReady) begin
          rankReg <= rankReg + 4'd1;
        end
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    inReady   = 1'b0;
    outValid  = 1'b0;
    done      = 1'b0;
    busy      = (stateReg != S_IDLE);
    case (stateReg)
      S_IDLE: begin
        if (start) stateNext = S_COLLECT;
      end
      S_COLLECT: begin
        inReady = 1'b1;
        if (inValid && (countReg == nReg - 9'd1)) stateNext = S_FLUSH;
      end
      // The last accepted candidate is inserted during this cycle.
      S_FLUSH: begin
        stateNext = S_OUTPUT;
      end
      S_OUTPUT: begin
        outValid = 1'b1;
        if (outReady && ({5'd0, rankReg} == lastRank)) stateNext = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    outMetric = '0;
    outIdx    = '0;
    outRank   = '0;
    if (outValid) begin
      outRank = rankReg;
      for (int i = 0; i < K; i++) begin
        if (rankReg == 4'(i)) begin
          outMetric = listMetricReg[i];
          outIdx    = listIdxReg[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_metric_sorter.sv
// Self-checking bench for metric_sorter: directed cases plus randomized runs
// compared against a stable-selection reference model.
module tb_metric_sorter;
  import sorter_pkg::*;

  localparam int WIDTH     = 16;
  localparam int IDX_WIDTH = 8;
  localparam int K         = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [1:0]              M;
  logic                    inValid;
  logic                    inReady;
  logic signed [WIDTH-1:0] inReal;
  logic signed [WIDTH-1:0] inImag;
  logic [IDX_WIDTH-1:0]    inIdx;
  logic                    outValid;
  logic                    outReady;
  logic [2*WIDTH-1:0]      outMetric;
  logic [IDX_WIDTH-1:0]    outIdx;
  logic [3:0]              outRank;
  logic                    busy;
  logic                    done;

  int checks = 0;
  int errors = 0;

  int candRe  [256];
  int candIm  [256];
  int candIdx [256];
  longint unsigned expMetric [K];
  int              expIdx    [K];
  int              expCount;

  metric_sorter #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH), .K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .M        (M),
    .inValid  (inValid),
    .inReady  (inReady),
    .inReal   (inReal),
    .inImag   (inImag),
    .inIdx    (inIdx),
    .outValid (outValid),
    .outReady (outReady),
    .outMetric(outMetric),
    .outIdx   (outIdx),
    .outRank  (outRank),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int numOf(input logic [1:0] mod);
    return (mod == 2'b00) ? 4 : (mod == 2'b01) ? 16 : (mod == 2'b10) ? 64 : 256;
  endfunction

  // Reference: repeatedly pick the smallest unused metric; strict '<' keeps
  // the earliest arrival on ties.
  function automatic void buildModel(input int n);
    bit              used [256];
    longint unsigned mt   [256];
    int              best;
    for (int i = 0; i < n; i++) begin
      used[i] = 1'b0;
      mt[i]   = longint'(candRe[i]) * longint'(candRe[i]) + longint'(candIm[i]) * longint'(candIm[i]);
    end
    expCount = (n < K) ? n : K;
    for (int r = 0; r < expCount; r++) begin
      best = -1;
      for (int i = 0; i < n; i++)
        if (!used[i] && (best < 0 || mt[i] < mt[best])) best = i;
      used[best]   = 1'b1;
      expMetric[r] = mt[best];
      expIdx[r]    = candIdx[best];
    end
  endfunction

  task automatic checkAllZero(input string tag);
    check({tag, "_inReady"},  64'(inReady),  64'(0));
    check({tag, "_outValid"}, 64'(outValid), 64'(0));
    check({tag, "_outMetric"},64'(outMetric),64'(0));
    check({tag, "_outIdx"},   64'(outIdx),   64'(0));
    check({tag, "_outRank"},  64'(outRank),  64'(0));
    check({tag, "_busy"},     64'(busy),     64'(0));
    check({tag, "_done"},     64'(done),     64'(0));
  endtask

  task automatic doStart(input logic [1:0] mod);
    @(negedge clk);
    M = mod; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    M = 2'($urandom);
    check("start_busy", 64'(busy), 64'(1));
    check("start_inReady", 64'(inReady), 64'(1));
  endtask

  task automatic feed(input int n, input bit expectClose, input bit gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          inValid = 1'b0;
          inReal  = WIDTH'($urandom);
          inImag  = WIDTH'($urandom);
          @(negedge clk);
        end
      end
      inValid = 1'b1;
      inReal  = candRe[i][WIDTH-1:0];
      inImag  = candIm[i][WIDTH-1:0];
      inIdx   = candIdx[i][IDX_WIDTH-1:0];
      guard = 0;
      while (!inReady && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check("inReady_timeout", 64'(inReady), 64'(1));
    end
    @(negedge clk);
    inValid = 1'b0;
    if (expectClose) check("inReady_after_last", 64'(inReady), 64'(0));
  endtask

  task automatic drain(input int stallRank, input int startAt);
    int guard;
    logic [2*WIDTH-1:0]   heldMetric;
    logic [IDX_WIDTH-1:0] heldIdx;
    for (int r = 0; r < expCount; r++) begin
      guard = 0;
      while (!outValid && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("outValid", 64'(outValid), 64'(1));
      check("outRank", 64'(outRank), 64'(r));
      check("outMetric", 64'(outMetric), 64'(expMetric[r]));
      check("outIdx", 64'(outIdx), 64'(expIdx[r]));
      $display("rank %0d: metric=%0d idx=%0d (expected %0d/%0d)", r, outMetric, outIdx, expMetric[r], expIdx[r]);
      if (r == stallRank) begin
        heldMetric = outMetric;
        heldIdx    = outIdx;
        outReady   = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_valid", 64'(outValid), 64'(1));
          check("stall_rank", 64'(outRank), 64'(r));
          check("stall_metric", 64'(outMetric), 64'(heldMetric));
          check("stall_idx", 64'(outIdx), 64'(heldIdx));
        end
      end
      outReady = 1'b1;
      if (r == startAt) begin
        start = 1'b1;
        M     = 2'b11;
      end
      @(negedge clk);
      outReady = 1'b0;
      start    = 1'b0;
    end
    check("done_pulse", 64'(done), 64'(1));
    check("done_outValid", 64'(outValid), 64'(0));
    @(negedge clk);
    check("done_clear", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic runCase(input logic [1:0] mod, input int stallRank, input int startAt, input bit gaps);
    int n;
    n = numOf(mod);
    buildModel(n);
    doStart(mod);
    feed(n, 1'b1, gaps);
    drain(stallRank, startAt);
  endtask

  task automatic randomCands(input int n, input bit smallRange);
    for (int i = 0; i < n; i++) begin
      if (smallRange) begin
        candRe[i] = int'($urandom_range(0, 16)) - 8;
        candIm[i] = int'($urandom_range(0, 16)) - 8;
      end else begin
        candRe[i] = int'($urandom_range(0, 65535)) - 32768;
        candIm[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      candIdx[i] = int'($urandom_range(0, 255));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; M = 2'b00; inValid = 1'b0; outReady = 1'b0;
    inReal = '0; inImag = '0; inIdx = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // No start: valid data must not be taken.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inValid = 1'b1;
      inReal  = WIDTH'($urandom);
      check("idle_inReady", 64'(inReady), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
    end
    @(negedge clk);
    inValid = 1'b0;

    // QPSK directed, stall at rank 1, start during OUTPUT ignored.
    candRe[0] = 3; candIm[0] = 2; candIdx[0] = 0;
    candRe[1] = 5; candIm[1] = 1; candIdx[1] = 1;
    candRe[2] = 7; candIm[2] = 4; candIdx[2] = 2;
    candRe[3] = 1; candIm[3] = 1; candIdx[3] = 3;
    runCase(MOD_QPSK, 1, 2, 1'b0);

    // QAM16 ties: all metric 2, earliest four survive.
    for (int i = 0; i < 16; i++) begin
      candRe[i] = 1; candIm[i] = -1; candIdx[i] = i;
    end
    runCase(MOD_QAM16, -1, -1, 1'b0);

    // QAM64 extreme magnitude never survives.
    for (int i = 0; i < 64; i++) begin
      candRe[i] = 100; candIm[i] = 0; candIdx[i] = i;
    end
    candRe[40] = -32768; candIm[40] = -32768;
    runCase(MOD_QAM64, -1, -1, 1'b1);

    // Reset mid-COLLECT after 5 accepts of zero-metric candidates.
    for (int i = 0; i < 5; i++) begin
      candRe[i] = 0; candIm[i] = 0; candIdx[i] = 200 + i;
    end
    doStart(MOD_QAM16);
    feed(5, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    @(negedge clk);
    checkAllZero("midreset_hold");
    rst = 1'b0;
    randomCands(4, 1'b0);
    runCase(MOD_QPSK, -1, -1, 1'b0);

    // Randomized runs over all modulations.
    for (int t = 0; t < 8; t++) begin
      logic [1:0] mod;
      mod = 2'(t % 4);
      randomCands(numOf(mod), t[0]);
      runCase(mod, int'($urandom_range(0, 3)), -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
